// File: rtl/vector_uop_sequencer.sv
// Splits an accepted vector instruction into 4-element micro-ops.
// Each uop carries its index, per-lane active bits and the latched mask enable.
module vector_uop_sequencer #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_ELEMS = 128,
    parameter int unsigned UOP_W     = 5,
    parameter int unsigned VL_W      = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [VL_W-1:0]  instr_vl,
    input  logic [VL_W-1:0]  instr_vstart,
    input  logic             instr_vm,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [UOP_W-1:0] uop_num,
    output logic [LANES-1:0] lane_active,
    output logic             mask_enable,
    output logic             uop_first,
    output logic             uop_last,
    output logic             instr_done
);

    localparam int unsigned IDX_W = 7;
    localparam int unsigned ELE_W = IDX_W + 2;

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q;
    logic [VL_W-1:0]  vl_q;
    logic [VL_W-1:0]  vstart_q;
    logic [IDX_W-1:0] last_q;

    logic [VL_W-1:0]  vl_clamped;
    logic [IDX_W-1:0] acc_first;
    logic [IDX_W-1:0] acc_last;
    logic             acc_empty;
    logic [IDX_W-1:0] next_num;

    // Lane i of uop k covers element 4k+i; 9-bit element index never overflows.
    function automatic logic [LANES-1:0] lanes_for(input logic [IDX_W-1:0] k,
                                                   input logic [VL_W-1:0]  vl,
                                                   input logic [VL_W-1:0]  vs);
        logic [LANES-1:0] res;
        logic [ELE_W-1:0] e;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            e      = {k, 2'b00} + ELE_W'(i);
            res[i] = (e >= ELE_W'(vs)) && (e < ELE_W'(vl));
        end
        return res;
    endfunction

    always_comb begin
        vl_clamped = (32'(instr_vl) > MAX_ELEMS) ? VL_W'(MAX_ELEMS) : instr_vl;
        acc_first  = IDX_W'(instr_vstart >> 2);
        acc_last   = IDX_W'((vl_clamped - VL_W'(1)) >> 2);
        acc_empty  = (vl_clamped == '0) || (instr_vstart >= vl_clamped);
        next_num   = IDX_W'(uop_num) + IDX_W'(1);
    end

    assign instr_ready = (state_q == StIdle) && !flush;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= StIdle;
            vl_q        <= '0;
            vstart_q    <= '0;
            last_q      <= '0;
            uop_valid   <= 1'b0;
            uop_num     <= '0;
            lane_active <= '0;
            mask_enable <= 1'b0;
            uop_first   <= 1'b0;
            uop_last    <= 1'b0;
            instr_done  <= 1'b0;
        end else if (flush) begin
            state_q    <= StIdle;
            uop_valid  <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    instr_done <= 1'b0;
                    if (instr_valid) begin
                        vl_q        <= vl_clamped;
                        vstart_q    <= instr_vstart;
                        last_q      <= acc_last;
                        mask_enable <= !instr_vm;
                        if (acc_empty) begin
                            instr_done <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            uop_valid   <= 1'b1;
                            uop_num     <= UOP_W'(acc_first);
                            uop_first   <= 1'b1;
                            uop_last    <= (acc_first == acc_last);
                            lane_active <= lanes_for(acc_first, vl_clamped, instr_vstart);
                        end
                    end
                end
                StRun: begin
                    if (uop_ready) begin
                        if (uop_last) begin
                            state_q     <= StIdle;
                            uop_valid   <= 1'b0;
                            uop_first   <= 1'b0;
                            uop_last    <= 1'b0;
                            lane_active <= '0;
                            instr_done  <= 1'b1;
                        end else begin
                            uop_num     <= UOP_W'(next_num);
                            uop_first   <= 1'b0;
                            uop_last    <= (next_num == last_q);
                            lane_active <= lanes_for(next_num, vl_q, vstart_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Scoreboard bench for vector_uop_sequencer: expected uops are queued per
// instruction and compared against the handshakes recorded by a monitor.
module tb_vector_uop_sequencer;

    logic       CLK;
    logic       nRST;
    logic       flush;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_vl;
    logic [7:0] instr_vstart;
    logic       instr_vm;
    logic       uop_valid;
    logic       uop_ready;
    logic [4:0] uop_num;
    logic [3:0] lane_active;
    logic       mask_enable;
    logic       uop_first;
    logic       uop_last;
    logic       instr_done;

    vector_uop_sequencer #(
        .LANES(4), .MAX_ELEMS(128), .UOP_W(5), .VL_W(8)
    ) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_vl(instr_vl), .instr_vstart(instr_vstart), .instr_vm(instr_vm),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_num(uop_num),
        .lane_active(lane_active), .mask_enable(mask_enable),
        .uop_first(uop_first), .uop_last(uop_last), .instr_done(instr_done)
    );

    typedef struct packed {
        logic [4:0] num;
        logic [3:0] lanes;
        logic       mask;
        logic       first;
        logic       last;
    } uop_t;

    uop_t exp_q[$];
    uop_t obs_q[$];
    int   obs_cyc[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   overlap_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Records every uop handshake and done pulse outside reset.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (uop_valid && uop_ready) begin
                obs_q.push_back({uop_num, lane_active, mask_enable, uop_first, uop_last});
                obs_cyc.push_back(cyc);
            end
            if (instr_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (instr_done && uop_valid) overlap_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic expect_uop(input logic [4:0] n, input logic [3:0] l, input logic m,
                              input logic f, input logic la);
        exp_q.push_back({n, l, m, f, la});
    endtask

    task automatic issue(input int vl, input int vs, input logic vm);
        bit ok;
        ok           = 1'b0;
        instr_vl     = vl[7:0];
        instr_vstart = vs[7:0];
        instr_vm     = vm;
        instr_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_ready got 0 want 1 (vl=%0d vs=%0d)", vl, vs);
        end
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        n_tests++;
        if ({uop_valid, uop_num, lane_active, mask_enable, uop_first, uop_last, instr_done}
            !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", {uop_valid, uop_num, lane_active,
                     mask_enable, uop_first, uop_last, instr_done});
        end
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", instr_ready);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_sb();
        uop_ready = 1'b1;
        issue(10, 0, 1'b1);
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_uop(5'd1, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_uop(5'd2, 4'b0011, 1'b0, 1'b0, 1'b1);
        repeat (6) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL basic_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (obs_cyc[2] - obs_cyc[0] !== 2) begin
                n_fail++;
                $display("FAIL basic_no_bubble got span %0d want 2", obs_cyc[2] - obs_cyc[0]);
            end
            n_tests++;
            if (done_cyc !== obs_cyc[2] + 1) begin
                n_fail++;
                $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, obs_cyc[2] + 1);
            end
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_vstart();
        clear_sb();
        uop_ready = 1'b1;
        issue(16, 6, 1'b0);
        expect_uop(5'd1, 4'b1100, 1'b1, 1'b1, 1'b0);
        expect_uop(5'd2, 4'b1111, 1'b1, 1'b0, 1'b0);
        expect_uop(5'd3, 4'b1111, 1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL vstart_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL vstart_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL vstart_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_stall();
        clear_sb();
        uop_ready = 1'b0;
        issue(8, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_tests++;
            if ({uop_valid, uop_num, lane_active} !== {1'b1, 5'd0, 4'b1111}) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b n=%0d l=%b want v=1 n=0 l=1111",
                         c, uop_valid, uop_num, lane_active);
            end
            tick();
        end
        uop_ready = 1'b1;
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_uop(5'd1, 4'b1111, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL stall_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL stall_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_edges();
        int vls[2];
        vls[0] = 0;
        vls[1] = 5;
        clear_sb();
        uop_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            issue(vls[j], vls[j], 1'b1);
            @(negedge CLK);
            n_tests++;
            if ({uop_valid, instr_done} !== 2'b01) begin
                n_fail++;
                $display("FAIL empty%0d_pulse got v=%b d=%b want v=0 d=1", j, uop_valid,
                         instr_done);
            end
            tick();
            @(negedge CLK);
            n_tests++;
            if ({uop_valid, instr_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL empty%0d_after got v=%b d=%b want 0 0", j, uop_valid,
                         instr_done);
            end
            tick();
        end
        n_tests++;
        if (obs_q.size() !== 0 || done_cnt !== 2) begin
            n_fail++;
            $display("FAIL empty_totals got uops=%0d done=%0d want 0 2", obs_q.size(),
                     done_cnt);
        end
        clear_sb();
        issue(200, 0, 1'b1);
        for (int k = 0; k < 32; k++)
            expect_uop(k[4:0], 4'b1111, 1'b0, k == 0, k == 31);
        repeat (40) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL clamp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clamp_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL clamp_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_flush();
        clear_sb();
        uop_ready = 1'b1;
        issue(12, 0, 1'b1);
        tick();
        uop_ready    = 1'b0;
        flush        = 1'b1;
        instr_vl     = 8'd4;
        instr_vstart = 8'd0;
        instr_vm     = 1'b1;
        instr_valid  = 1'b1;
        @(negedge CLK);
        n_tests++;
        if ({uop_num, instr_ready} !== {5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_setup got n=%0d rdy=%b want n=1 rdy=0", uop_num, instr_ready);
        end
        tick();
        flush       = 1'b0;
        instr_valid = 1'b0;
        uop_ready   = 1'b1;
        @(negedge CLK);
        n_tests++;
        if ({uop_valid, instr_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_kill got v=%b d=%b want 0 0", uop_valid, instr_done);
        end
        tick();
        issue(4, 0, 1'b1);
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b1);
        repeat (4) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL flush_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL flush_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL flush_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        uop_ready = 1'b1;
        issue(12, 0, 1'b0);
        nRST = 1'b0;
        tick();
        @(negedge CLK);
        n_tests++;
        if ({uop_valid, uop_num, lane_active, mask_enable, uop_first, uop_last, instr_done,
             instr_ready} !== 15'd1) begin
            n_fail++;
            $display("FAIL midrst_outputs got %b want 000000000000001", {uop_valid, uop_num,
                     lane_active, mask_enable, uop_first, uop_last, instr_done, instr_ready});
        end
        nRST = 1'b1;
        tick();
        issue(4, 0, 1'b1);
        issue(5, 0, 1'b1);
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b1);
        expect_uop(5'd0, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_uop(5'd1, 4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_uop%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (obs_cyc[1] - obs_cyc[0] !== 2) begin
                n_fail++;
                $display("FAIL b2b_gap got %0d want 2", obs_cyc[1] - obs_cyc[0]);
            end
        end
        n_tests++;
        if (done_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 2", done_cnt);
        end
    endtask

    initial begin
        nRST         = 1'b0;
        flush        = 1'b0;
        instr_valid  = 1'b0;
        instr_vl     = '0;
        instr_vstart = '0;
        instr_vm     = 1'b1;
        uop_ready    = 1'b0;
        test_reset();
        test_basic();
        test_vstart();
        test_stall();
        test_edges();
        test_flush();
        test_back_to_back();
        n_tests++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_overlap got %0d want 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
